alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//   Parametrised multi-cycle controller for the 8-bit ALU family, generalised to WIDTH-bit datapaths.
//   Sequences add/sub (single-cycle), radix-2 Booth multiply and non-restoring divide.
//   Owns its own iteration counter, so no counter_done inputs are needed. Adds op latching,
//   abort, divide-by-zero trapping and a busy/done handshake. Sits between the ALU top level and the datapath units.
// PARAMETERS
//   WIDTH  8                        operand width; Booth and divide iteration count
//   CNT_W  $clog2(WIDTH+1) (derived) iter_count width
// PORTS
//   clk               in   1      rising-edge clock
//   reset_n           in   1      asynchronous, active-low reset
//   start             in   1      request; accepted only in IDLE
//   op_code           in   2      00 add, 01 sub, 10 mul, 11 div; latched on accept
//   abort             in   1      synchronous cancel of the current operation
//   booth_bits        in   2      {Q0,Q-1} from the Booth datapath
//   divider_sign_R    in   1      sign of the partial remainder (1 = negative)
//   divisor_zero      in   1      divisor == 0; sampled in DIV_LOAD
//   load_operands     out  1      asserted in LOAD
//   adder_en, subtractor_en    out 1 each  asserted in ADD_EXEC / SUB_EXEC
//   booth_load, booth_add_en, booth_sub_en, booth_shift_en  out 1 each  Booth datapath strobes
//   divider_load, divider_shift_en, divider_add_en, divider_sub_en, divider_final_add  out 1 each  divider strobes
//   busy              out  1      1 in any state other than IDLE
//   alu_done          out  1      one-cycle completion pulse
//   div_by_zero       out  1      sticky error flag; cleared when the next start is accepted
//   iter_count        out  CNT_W  remaining iterations
// BEHAVIOUR
// - Reset (reset_n=0, asynchronous)
//   - State goes to IDLE; op register = 00; iter_count = 0; every output = 0.
// - Encoding and outputs
//   - One-hot state register. All outputs are decoded from the registered state only (Moore).
//   - Exception: divider_add_en, divider_sub_en and divider_final_add are also qualified by divider_sign_R.
// - Start acceptance
//   - IDLE & start -> LOAD. op_code is latched in the same cycle. start is ignored whenever busy=1.
// - Add / sub path
//   - LOAD -> ADD_EXEC or SUB_EXEC (per latched op) -> DONE -> IDLE.
//   - alu_done is high 3 cycles after the accept edge.
// - Multiply path
//   - LOAD -> MUL_LOAD. In MUL_LOAD, iter_count <= WIDTH.
//   - MUL_CHECK: booth_bits 01 -> MUL_ADD; 10 -> MUL_SUB; 00 or 11 -> MUL_SHIFT.
//   - MUL_ADD and MUL_SUB -> MUL_SHIFT.
//   - MUL_SHIFT: iter_count decrements. If iter_count==1 at entry -> DONE, else -> MUL_CHECK.
// - Divide path
//   - LOAD -> DIV_LOAD. In DIV_LOAD, iter_count <= WIDTH.
//   - If divisor_zero=1 in DIV_LOAD -> DIV_ERR: div_by_zero <= 1, then -> DONE. No shift, add or sub strobes are issued.
//   - Otherwise DIV_SHIFT -> DIV_OP. In DIV_OP: divider_add_en = sign_R, divider_sub_en = ~sign_R; iter_count decrements.
//   - DIV_OP with iter_count==1 -> DIV_CORR, else -> DIV_SHIFT.
//   - DIV_CORR: divider_final_add = sign_R. Then -> DONE.
// - DONE
//   - alu_done=1 for exactly one cycle, then -> IDLE.
//   - A start present in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
// - Abort
//   - abort=1 in any non-IDLE state -> IDLE on the next edge. No alu_done is produced and iter_count is cleared.
//   - abort takes priority over every other transition. abort in IDLE has no effect.
// - Width rules
//   - iter_count never wraps below 0.
//   - WIDTH=1 is legal: one Booth iteration, or one shift+op pair for divide.
// - Invalid state
//   - Any non-one-hot state recovers to IDLE on the next edge.
// TESTING
// - Add: reset, start op=00 -> load_operands in cycle 1, adder_en in cycle 2, alu_done in cycle 3, busy low in cycle 4.
// - Multiply, WIDTH=8, booth_bits held 00 -> exactly 8 MUL_SHIFT cycles, no add/sub strobes, alu_done 19 cycles after accept.
// - Multiply with booth_bits 01 on the 1st check and 10 on the 3rd -> exactly one booth_add_en and one booth_sub_en,
//   alu_done 21 cycles after accept.
// - Divide, WIDTH=8, sign_R alternating -> 8 shift/op pairs with add/sub following sign_R; final_add only if sign_R=1
//   in DIV_CORR; alu_done 20 cycles after accept.
// - Divide with divisor_zero=1 -> div_by_zero=1 and alu_done 4 cycles after accept, with zero shift strobes;
//   a following add clears div_by_zero.
// - abort in MUL_SHIFT, and reset_n low mid-divide -> IDLE, every output 0, no alu_done;
//   start held high while busy -> ignored.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for the WIDTH-bit ALU datapath.
// Sequences single-cycle add/sub, radix-2 Booth multiply and non-restoring
// divide. It owns the iteration counter, traps divide-by-zero and supports abort.
//
// Handshake: start is sampled only while busy=0 (IDLE). The edge that samples
// start=1 in IDLE is the accept edge, and op_code is latched on that same edge.
// busy stays high from the following cycle until the cycle after DONE.
// alu_done is a one-cycle pulse in DONE, and busy is still high in that cycle.
// abort cancels any busy operation on the next edge without producing alu_done.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op_code,
    input  logic             abort,
    input  logic [1:0]       booth_bits,
    input  logic             divider_sign_R,
    input  logic             divisor_zero,
    output logic             load_operands,
    output logic             adder_en,
    output logic             subtractor_en,
    output logic             booth_load,
    output logic             booth_add_en,
    output logic             booth_sub_en,
    output logic             booth_shift_en,
    output logic             divider_load,
    output logic             divider_shift_en,
    output logic             divider_add_en,
    output logic             divider_sub_en,
    output logic             divider_final_add,
    output logic             busy,
    output logic             alu_done,
    output logic             div_by_zero,
    output logic [CNT_W-1:0] iter_count,
    output logic [14:0]      dbg_state
);

    typedef enum logic [14:0] {
        S_IDLE      = 15'h0001,
        S_LOAD      = 15'h0002,
        S_ADD_EXEC  = 15'h0004,
        S_SUB_EXEC  = 15'h0008,
        S_MUL_LOAD  = 15'h0010,
        S_MUL_CHECK = 15'h0020,
        S_MUL_ADD   = 15'h0040,
        S_MUL_SUB   = 15'h0080,
        S_MUL_SHIFT = 15'h0100,
        S_DIV_LOAD  = 15'h0200,
        S_DIV_ERR   = 15'h0400,
        S_DIV_SHIFT = 15'h0800,
        S_DIV_OP    = 15'h1000,
        S_DIV_CORR  = 15'h2000,
        S_DONE      = 15'h4000
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             r_dbz;
    logic             w_dbz_next;
    logic             w_accept;

    assign w_accept  = (r_state == S_IDLE) && start;
    // Saturating decrement: the counter never wraps below zero.
    assign w_cnt_dec = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : r_cnt;

    // State, counter, error flag and latched opcode registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_dbz   <= w_dbz_next;
            if (w_accept) begin
                r_op <= op_code;
            end
        end
    end

    // Next-state, counter and error-flag logic; abort overrides every transition.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_dbz_next   = r_dbz;
        if (abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next = S_LOAD;
                        w_dbz_next   = 1'b0;
                    end
                end
                S_LOAD: begin
                    case (r_op)
                        2'b00:   w_state_next = S_ADD_EXEC;
                        2'b01:   w_state_next = S_SUB_EXEC;
                        2'b10:   w_state_next = S_MUL_LOAD;
                        default: w_state_next = S_DIV_LOAD;
                    endcase
                end
                S_ADD_EXEC, S_SUB_EXEC: w_state_next = S_DONE;
                S_MUL_LOAD: begin
                    w_cnt_next   = CNT_W'(WIDTH);
                    w_state_next = S_MUL_CHECK;
                end
                S_MUL_CHECK: begin
                    case (booth_bits)
                        2'b01:   w_state_next = S_MUL_ADD;
                        2'b10:   w_state_next = S_MUL_SUB;
                        default: w_state_next = S_MUL_SHIFT;
                    endcase
                end
                S_MUL_ADD, S_MUL_SUB: w_state_next = S_MUL_SHIFT;
                S_MUL_SHIFT: begin
                    w_cnt_next   = w_cnt_dec;
                    // A zero count can only come from a corrupted state; finish rather than loop.
                    w_state_next = (r_cnt <= CNT_W'(1)) ? S_DONE : S_MUL_CHECK;
                end
                S_DIV_LOAD: begin
                    w_cnt_next = CNT_W'(WIDTH);
                    if (divisor_zero) begin
                        w_state_next = S_DIV_ERR;
                        w_dbz_next   = 1'b1;
                    end else begin
                        w_state_next = S_DIV_SHIFT;
                    end
                end
                S_DIV_ERR:   w_state_next = S_DONE;
                S_DIV_SHIFT: w_state_next = S_DIV_OP;
                S_DIV_OP: begin
                    w_cnt_next   = w_cnt_dec;
                    w_state_next = (r_cnt <= CNT_W'(1)) ? S_DIV_CORR : S_DIV_SHIFT;
                end
                S_DIV_CORR: w_state_next = S_DONE;
                S_DONE:     w_state_next = S_IDLE;
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Moore decode of the registered state; only the divider add/sub/final strobes look at sign_R.
    assign load_operands     = (r_state == S_LOAD);
    assign adder_en          = (r_state == S_ADD_EXEC);
    assign subtractor_en     = (r_state == S_SUB_EXEC);
    assign booth_load        = (r_state == S_MUL_LOAD);
    assign booth_add_en      = (r_state == S_MUL_ADD);
    assign booth_sub_en      = (r_state == S_MUL_SUB);
    assign booth_shift_en    = (r_state == S_MUL_SHIFT);
    assign divider_load      = (r_state == S_DIV_LOAD);
    assign divider_shift_en  = (r_state == S_DIV_SHIFT);
    assign divider_add_en    = (r_state == S_DIV_OP) && divider_sign_R;
    assign divider_sub_en    = (r_state == S_DIV_OP) && !divider_sign_R;
    assign divider_final_add = (r_state == S_DIV_CORR) && divider_sign_R;
    assign busy              = (r_state != S_IDLE);
    assign alu_done          = (r_state == S_DONE);
    assign div_by_zero       = r_dbz;
    assign iter_count        = r_cnt;
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized bench for alu_sequencer with a timeline model
// and a scoreboard that is checked whenever a busy period ends.
module tb_alu_sequencer;

    localparam int W   = 8;
    localparam int CW  = $clog2(W + 1);
    localparam int NCH = 15;
    // Channel indices into the observed strobe vector; channel 14 is iter_count.
    localparam int C_LOAD = 0, C_ADD = 1, C_SUB = 2, C_BLOAD = 3, C_BADD = 4;
    localparam int C_BSUB = 5, C_BSHIFT = 6, C_DLOAD = 7, C_DSHIFT = 8;
    localparam int C_DADD = 9, C_DSUB = 10, C_DFIN = 11, C_DONE = 12, C_DBZ = 13;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [1:0]    op_code;
    logic          abort;
    logic [1:0]    booth_bits;
    logic          divider_sign_R;
    logic          divisor_zero;
    logic          load_operands, adder_en, subtractor_en;
    logic          booth_load, booth_add_en, booth_sub_en, booth_shift_en;
    logic          divider_load, divider_shift_en, divider_add_en, divider_sub_en, divider_final_add;
    logic          busy, alu_done, div_by_zero;
    logic [CW-1:0] iter_count;
    logic [14:0]   dbg_state;
    logic [13:0]   obs;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_code(op_code), .abort(abort),
        .booth_bits(booth_bits), .divider_sign_R(divider_sign_R), .divisor_zero(divisor_zero),
        .load_operands(load_operands), .adder_en(adder_en), .subtractor_en(subtractor_en),
        .booth_load(booth_load), .booth_add_en(booth_add_en), .booth_sub_en(booth_sub_en),
        .booth_shift_en(booth_shift_en), .divider_load(divider_load),
        .divider_shift_en(divider_shift_en), .divider_add_en(divider_add_en),
        .divider_sub_en(divider_sub_en), .divider_final_add(divider_final_add),
        .busy(busy), .alu_done(alu_done), .div_by_zero(div_by_zero),
        .iter_count(iter_count), .dbg_state(dbg_state)
    );

    assign obs = {div_by_zero, alu_done, divider_final_add, divider_sub_en, divider_add_en,
                  divider_shift_en, divider_load, booth_shift_en, booth_sub_en, booth_add_en,
                  booth_load, subtractor_en, adder_en, load_operands};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  bb;
        logic        sg;
        logic        dz;
        logic [13:0] f;
        int          it;
    } cyc_t;

    typedef struct {
        int   ncyc;
        int   cnt[NCH];
        int   pos[NCH];
        logic dbz_end;
        int   iter_end;
    } exp_t;

    cyc_t tl[$];
    exp_t exp_q[$];
    int   model_iter;
    logic [1:0] bseq[W];
    logic       sseq[W+1];
    int   vectors;
    int   miscompares;
    int   txn_no;

    function automatic logic [1:0] rb();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic logic rs();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic string ch_name(input int c);
        case (c)
            0: return "load_operands";   1: return "adder_en";        2: return "subtractor_en";
            3: return "booth_load";      4: return "booth_add_en";    5: return "booth_sub_en";
            6: return "booth_shift_en";  7: return "divider_load";    8: return "divider_shift_en";
            9: return "divider_add_en"; 10: return "divider_sub_en"; 11: return "divider_final_add";
            12: return "alu_done";      13: return "div_by_zero";
            default: return "iter_count";
        endcase
    endfunction

    // One expected busy cycle: which strobe fires, the counter value shown, and input values to drive.
    task automatic push_c(input int ch, input int it, input logic [1:0] bb, input logic sg,
                          input logic dz, input logic dbz);
        cyc_t c;
        c.f = '0;
        if (ch >= 0) c.f[ch] = 1'b1;
        c.f[C_DBZ] = dbz;
        c.it = it;
        c.bb = bb;
        c.sg = sg;
        c.dz = dz;
        tl.push_back(c);
    endtask

    // Builds the cycle-by-cycle timeline of one operation from the sequencing rules.
    task automatic build(input logic [1:0] op, input logic dz, input int t_ab_req,
                         output int t_ab_eff, output exp_t e);
        int it;
        tl.delete();
        it = model_iter;
        push_c(C_LOAD, it, rb(), rs(), rs(), 1'b0);
        case (op)
            2'd0: begin
                push_c(C_ADD, it, rb(), rs(), rs(), 1'b0);
                push_c(C_DONE, it, rb(), rs(), rs(), 1'b0);
            end
            2'd1: begin
                push_c(C_SUB, it, rb(), rs(), rs(), 1'b0);
                push_c(C_DONE, it, rb(), rs(), rs(), 1'b0);
            end
            2'd2: begin
                push_c(C_BLOAD, it, rb(), rs(), rs(), 1'b0);
                it = W;
                for (int i = 0; i < W; i++) begin
                    push_c(-1, it, bseq[i], rs(), rs(), 1'b0);
                    if (bseq[i] == 2'b01) push_c(C_BADD, it, rb(), rs(), rs(), 1'b0);
                    else if (bseq[i] == 2'b10) push_c(C_BSUB, it, rb(), rs(), rs(), 1'b0);
                    push_c(C_BSHIFT, it, rb(), rs(), rs(), 1'b0);
                    it = it - 1;
                end
                push_c(C_DONE, it, rb(), rs(), rs(), 1'b0);
            end
            default: begin
                push_c(C_DLOAD, it, rb(), rs(), dz, 1'b0);
                it = W;
                if (dz) begin
                    push_c(-1, it, rb(), rs(), rs(), 1'b1);
                    push_c(C_DONE, it, rb(), rs(), rs(), 1'b1);
                end else begin
                    for (int i = 0; i < W; i++) begin
                        push_c(C_DSHIFT, it, rb(), rs(), rs(), 1'b0);
                        push_c(sseq[i] ? C_DADD : C_DSUB, it, rb(), sseq[i], rs(), 1'b0);
                        it = it - 1;
                    end
                    push_c(sseq[W] ? C_DFIN : -1, it, rb(), sseq[W], rs(), 1'b0);
                    push_c(C_DONE, it, rb(), rs(), rs(), 1'b0);
                end
            end
        endcase
        t_ab_eff = (t_ab_req > 0 && t_ab_req <= tl.size()) ? t_ab_req : 0;
        if (t_ab_eff > 0) begin
            while (tl.size() > t_ab_eff) void'(tl.pop_back());
            model_iter = 0;
        end else begin
            model_iter = it;
        end
        e.ncyc = tl.size();
        for (int c = 0; c < NCH; c++) begin
            e.cnt[c] = 0;
            e.pos[c] = 0;
        end
        for (int k = 0; k < tl.size(); k++) begin
            for (int c = 0; c < 14; c++) begin
                if (tl[k].f[c]) begin
                    e.cnt[c] += 1;
                    e.pos[c] += k + 1;
                end
            end
            e.cnt[14] += tl[k].it;
            e.pos[14] += (k + 1) * tl[k].it;
        end
        e.dbz_end  = tl[tl.size()-1].f[C_DBZ];
        e.iter_end = model_iter;
    endtask

    // ---------------- checks ----------------
    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        vectors++;
        if ({obs, busy, iter_count} !== '0 || dbg_state !== 15'h0001) begin
            miscompares++;
            $display("FAIL %s: outputs %h busy %b iter %0d state %h, expected all zero in IDLE",
                     nm, obs, busy, iter_count, dbg_state);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input logic [1:0] op, input logic dz, input int t_ab_req,
                           input int t_rst, input int gap);
        exp_t e;
        int   t_ab;
        build(op, dz, (t_rst > 0) ? t_rst - 1 : t_ab_req, t_ab, e);
        if (t_rst > 0) begin
            t_ab = 0;
            e.dbz_end = 1'b0;
        end
        exp_q.push_back(e);
        repeat (gap) begin
            start = 1'b0; abort = rs(); op_code = rb();
            booth_bits = rb(); divider_sign_R = rs(); divisor_zero = rs();
            @(posedge clk); #1;
        end
        start = 1'b1; op_code = op; abort = rs();
        @(posedge clk); #1;
        for (int t = 1; t <= e.ncyc; t++) begin
            booth_bits = tl[t-1].bb; divider_sign_R = tl[t-1].sg; divisor_zero = tl[t-1].dz;
            start = rs(); op_code = rb(); abort = (t == t_ab);
            @(posedge clk); #1;
        end
        if (t_rst > 0) begin
            start = rs(); abort = 1'b0; booth_bits = rb();
            #1 reset_n = 1'b0;
            #1 check_reset("mid_reset");
            @(posedge clk); #1;
            reset_n = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   mcyc;
    int   acnt[NCH];
    int   apos[NCH];
    logic prev_busy;

    task automatic finalize();
        exp_t e;
        txn_no++;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL txn%0d unexpected: busy period of %0d cycles with no expected entry", txn_no, mcyc);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("txn%0d busy_cycles", txn_no), mcyc, e.ncyc);
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("txn%0d %s count", txn_no, ch_name(c)), acnt[c], e.cnt[c]);
                chk($sformatf("txn%0d %s cycle_sum", txn_no, ch_name(c)), apos[c], e.pos[c]);
            end
            chk($sformatf("txn%0d div_by_zero_after", txn_no), int'(div_by_zero), int'(e.dbz_end));
            chk($sformatf("txn%0d iter_count_after", txn_no), int'(iter_count), e.iter_end);
        end
        mcyc = 0;
        for (int c = 0; c < NCH; c++) begin
            acnt[c] = 0;
            apos[c] = 0;
        end
    endtask

    initial begin
        mcyc = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            acnt[c] = 0;
            apos[c] = 0;
        end
    end

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            mcyc++;
            for (int c = 0; c < 14; c++) begin
                if (obs[c] === 1'b1) begin
                    acnt[c] += 1;
                    apos[c] += mcyc;
                end
            end
            acnt[14] += int'(iter_count);
            apos[14] += mcyc * int'(iter_count);
        end else if (prev_busy) begin
            finalize();
        end
        prev_busy = (busy === 1'b1);
    end

    // ---------------- stimulus ----------------
    initial begin
        vectors = 0; miscompares = 0; txn_no = 0; model_iter = 0;
        reset_n = 1'b0; start = 1'b0; op_code = 2'b00; abort = 1'b0;
        booth_bits = 2'b00; divider_sign_R = 1'b0; divisor_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i <= W; i++) sseq[i] = rs();
        // add, plain multiply, multiply with one add and one sub
        run_txn(2'd0, 1'b0, 0, 0, 1);
        for (int i = 0; i < W; i++) bseq[i] = 2'b00;
        run_txn(2'd2, 1'b0, 0, 0, 1);
        bseq[0] = 2'b01; bseq[2] = 2'b10;
        run_txn(2'd2, 1'b0, 0, 0, 0);
        // divide with alternating sign, then divide by zero followed by an add
        for (int i = 0; i < W; i++) sseq[i] = 1'(i % 2);
        sseq[W] = 1'b1;
        run_txn(2'd3, 1'b0, 0, 0, 1);
        run_txn(2'd3, 1'b1, 0, 0, 1);
        run_txn(2'd0, 1'b0, 0, 0, 0);
        // abort in the first MUL_SHIFT, reset in the middle of a divide, then a subtract
        for (int i = 0; i < W; i++) bseq[i] = 2'b00;
        run_txn(2'd2, 1'b0, 4, 0, 1);
        run_txn(2'd3, 1'b0, 0, 6, 1);
        run_txn(2'd1, 1'b0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            logic       dz;
            int         t_ab;
            op = rb();
            dz = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < W; i++) bseq[i] = rb();
            for (int i = 0; i <= W; i++) sseq[i] = rs();
            t_ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : 0;
            run_txn(op, dz, t_ab, 0, int'($urandom_range(0, 2)));
        end

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
